// File: rtl/pl_int_collector.sv
// Interrupt collector: per-source rising-edge capture, pending/miss/count state,
// aggregated level IRQ with holdoff. Optional FIQ routing: define PL_INT_FIQ_ROUTE_EN.

// Level-IRQ generator: asserts on request, then enforces a minimum low gap once it drops.
module pl_int_irq_fsm #(
  parameter int HOLDOFF_CYC = 4
) (
  input  logic clk100,
  input  logic rst,
  input  logic req_i,
  output logic irq_o
);

  localparam int TMR_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = (HOLDOFF_CYC > 0) ? TMR_W'(HOLDOFF_CYC - 1) : '0;

  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      irq_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            state <= ASSERT;
            irq_o <= 1'b1;
          end
        end
        ASSERT: begin
          if (!req_i) begin
            irq_o <= 1'b0;
            if (HOLDOFF_CYC == 0) begin
              state <= IDLE;
            end else begin
              state <= HOLDOFF;
              timer <= TMR_LOAD;
            end
          end
        end
        HOLDOFF: begin
          // Requests are deliberately ignored here; pending bits keep latching upstream.
          if (timer == '0) state <= IDLE;
          else             timer <= timer - 1'b1;
        end
        default: begin
          state <= IDLE;
          irq_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

module pl_int_collector #(
  parameter int N_SRC       = 3,
  parameter int CNT_W       = 32,
  parameter int HOLDOFF_CYC = 4
) (
  input  logic                   clk100,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       src_i,
  input  logic [N_SRC-1:0]       en_i,
  input  logic [N_SRC-1:0]       clr_i,
  input  logic                   cnt_clr_i,
`ifdef PL_INT_FIQ_ROUTE_EN
  input  logic [N_SRC-1:0]       fiq_sel_i,
  output logic                   fiq_o,
`endif
  output logic                   irq_o,
  output logic [N_SRC-1:0]       pending_o,
  output logic [N_SRC-1:0]       miss_o,
  output logic [N_SRC*CNT_W-1:0] int_cnt_o
);

  logic [N_SRC-1:0] src_d;
  logic [N_SRC-1:0] acc;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] miss;
  logic [CNT_W-1:0] cnt [N_SRC];
  logic             req_irq;

  // Disabled sources are dropped outright: no pending, no miss, no count.
  assign acc = src_i & ~src_d & en_i;

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      // All-ones so a source already high when reset releases is not seen as an edge.
      src_d   <= '1;
      pending <= '0;
      miss    <= '0;
      for (int i = 0; i < N_SRC; i++) cnt[i] <= '0;
    end else begin
      src_d   <= src_i;
      pending <= (pending & ~clr_i) | acc;
      miss    <= cnt_clr_i ? '0 : (miss | (acc & pending & ~clr_i));
      for (int i = 0; i < N_SRC; i++) begin
        if (cnt_clr_i)                    cnt[i] <= acc[i] ? CNT_W'(1) : '0;
        else if (acc[i] && cnt[i] != '1)  cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign pending_o = pending;
  assign miss_o    = miss;

  for (genvar g = 0; g < N_SRC; g++) begin : g_cnt_out
    assign int_cnt_o[g*CNT_W +: CNT_W] = cnt[g];
  end

`ifdef PL_INT_FIQ_ROUTE_EN
  logic req_fiq;
  assign req_irq = |(pending & en_i & ~fiq_sel_i);
  assign req_fiq = |(pending & en_i & fiq_sel_i);

  pl_int_irq_fsm #(.HOLDOFF_CYC(HOLDOFF_CYC)) u_fiq_fsm (
    .clk100 (clk100),
    .rst    (rst),
    .req_i  (req_fiq),
    .irq_o  (fiq_o)
  );
`else
  assign req_irq = |(pending & en_i);
`endif

  pl_int_irq_fsm #(.HOLDOFF_CYC(HOLDOFF_CYC)) u_irq_fsm (
    .clk100 (clk100),
    .rst    (rst),
    .req_i  (req_irq),
    .irq_o  (irq_o)
  );

endmodule

// File: tb/tb_pl_int_collector.sv
// Scoreboard bench for pl_int_collector: default instance plus a CNT_W=4 instance
// sharing the same stimulus for the saturation scenario.
module tb_pl_int_collector;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int SW = 4;

  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  logic           rst;
  logic [N-1:0]   src_i, en_i, clr_i;
  logic           cnt_clr_i;
  logic           irq_o, irq_s;
  logic [N-1:0]   pending_o, miss_o, pend_s, miss_s;
  logic [N*W-1:0] int_cnt_o;
  logic [N*SW-1:0] cnt_s;
`ifdef PL_INT_FIQ_ROUTE_EN
  logic [N-1:0]   fiq_sel_i;
  logic           fiq_o, fiq_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [N*W-1:0] sb [$];
  logic [N*W-1:0] e;

  pl_int_collector #(.N_SRC(N), .CNT_W(W), .HOLDOFF_CYC(4)) dut (
    .clk100(clk100), .rst(rst), .src_i(src_i), .en_i(en_i), .clr_i(clr_i),
    .cnt_clr_i(cnt_clr_i),
`ifdef PL_INT_FIQ_ROUTE_EN
    .fiq_sel_i(fiq_sel_i), .fiq_o(fiq_o),
`endif
    .irq_o(irq_o), .pending_o(pending_o), .miss_o(miss_o), .int_cnt_o(int_cnt_o)
  );

  pl_int_collector #(.N_SRC(N), .CNT_W(SW), .HOLDOFF_CYC(4)) dut_sat (
    .clk100(clk100), .rst(rst), .src_i(src_i), .en_i(en_i), .clr_i(clr_i),
    .cnt_clr_i(cnt_clr_i),
`ifdef PL_INT_FIQ_ROUTE_EN
    .fiq_sel_i(fiq_sel_i), .fiq_o(fiq_s),
`endif
    .irq_o(irq_s), .pending_o(pend_s), .miss_o(miss_s), .int_cnt_o(cnt_s)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk100);
      #1;
    end
  endtask

  task automatic apply_reset(input logic [N-1:0] src);
    rst = 1'b1; src_i = src; en_i = '0; clr_i = '0; cnt_clr_i = 1'b0;
`ifdef PL_INT_FIQ_ROUTE_EN
    fiq_sel_i = '0;
`endif
    step(2);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    src_i = m;
    step();
    src_i = '0;
    step();
  endtask

  task automatic test_reset();
    apply_reset(3'b111);
    en_i = 3'b111;
    rst  = 1'b1;
    step();
    sb.push_back('0);
    e = sb.pop_front(); n_checks++;
    if ({irq_o, pending_o, miss_o} !== e[6:0]) begin
      n_fail++; $display("FAIL reset_flags: got %b expected %b", {irq_o, pending_o, miss_o}, e[6:0]);
    end
`ifdef PL_INT_FIQ_ROUTE_EN
    sb.push_back('0);
    e = sb.pop_front(); n_checks++;
    if (fiq_o !== e[0]) begin
      n_fail++; $display("FAIL reset_fiq: got %b expected %b", fiq_o, e[0]);
    end
`endif
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      sb.push_back('0);
      sb.push_back('0);
      e = sb.pop_front(); n_checks++;
      if ({irq_o, pending_o, miss_o} !== e[6:0]) begin
        n_fail++; $display("FAIL held_high_flags c%0d: got %b expected %b", c, {irq_o, pending_o, miss_o}, e[6:0]);
      end
      e = sb.pop_front(); n_checks++;
      if (int_cnt_o !== e) begin
        n_fail++; $display("FAIL held_high_cnt c%0d: got %h expected %h", c, int_cnt_o, e);
      end
    end
    src_i = '0;
    step();
  endtask

  task automatic test_single_pulse();
    apply_reset('0);
    en_i = 3'b001;
    step(2);
    src_i = 3'b001;
    sb.push_back(3'b001);
    sb.push_back(0);
    step();
    src_i = '0;
    e = sb.pop_front(); n_checks++;
    if (pending_o !== e[2:0]) begin
      n_fail++; $display("FAIL pulse_pending: got %b expected %b", pending_o, e[2:0]);
    end
    e = sb.pop_front(); n_checks++;
    if (irq_o !== e[0]) begin
      n_fail++; $display("FAIL pulse_irq_early: got %b expected %b", irq_o, e[0]);
    end
    sb.push_back(1);
    sb.push_back(1);
    step();
    e = sb.pop_front(); n_checks++;
    if (irq_o !== e[0]) begin
      n_fail++; $display("FAIL pulse_irq: got %b expected %b", irq_o, e[0]);
    end
    e = sb.pop_front(); n_checks++;
    if (int_cnt_o[W-1:0] !== e[W-1:0]) begin
      n_fail++; $display("FAIL pulse_cnt0: got %0d expected %0d", int_cnt_o[W-1:0], e[W-1:0]);
    end
    step(6);
    clr_i = 3'b001;
    sb.push_back(0);
    sb.push_back(1);
    step();
    clr_i = '0;
    e = sb.pop_front(); n_checks++;
    if (pending_o !== e[2:0]) begin
      n_fail++; $display("FAIL clr_pending: got %b expected %b", pending_o, e[2:0]);
    end
    e = sb.pop_front(); n_checks++;
    if (irq_o !== e[0]) begin
      n_fail++; $display("FAIL clr_irq_m1: got %b expected %b", irq_o, e[0]);
    end
    sb.push_back(0);
    step();
    e = sb.pop_front(); n_checks++;
    if (irq_o !== e[0]) begin
      n_fail++; $display("FAIL clr_irq_m2: got %b expected %b", irq_o, e[0]);
    end
  endtask

  task automatic test_holdoff();
    int low_cnt;
    int guard;
    apply_reset('0);
    en_i = 3'b011;
    step(2);
    pulse(3'b001);
    clr_i = 3'b001;
    step();
    clr_i = '0;
    src_i = 3'b010;
    step();
    src_i = '0;
    low_cnt = (irq_o == 1'b0) ? 1 : 0;
    guard = 0;
    while (irq_o == 1'b0 && guard < 20) begin
      step();
      guard++;
      if (irq_o == 1'b0) low_cnt++;
    end
    // Fall after clock k, IDLE after k+4, reassert after k+5: five low cycles.
    sb.push_back(5);
    sb.push_back(1);
    sb.push_back(3'b010);
    e = sb.pop_front(); n_checks++;
    if (low_cnt !== int'(e[31:0])) begin
      n_fail++; $display("FAIL holdoff_gap: got %0d expected %0d", low_cnt, e[31:0]);
    end
    e = sb.pop_front(); n_checks++;
    if (irq_o !== e[0]) begin
      n_fail++; $display("FAIL holdoff_reassert: got %b expected %b", irq_o, e[0]);
    end
    e = sb.pop_front(); n_checks++;
    if (pending_o !== e[2:0]) begin
      n_fail++; $display("FAIL holdoff_pending: got %b expected %b", pending_o, e[2:0]);
    end
  endtask

  task automatic test_miss();
    apply_reset('0);
    en_i = 3'b100;
    step(2);
    pulse(3'b100);
    pulse(3'b100);
    sb.push_back(3'b100);
    sb.push_back(2);
    e = sb.pop_front(); n_checks++;
    if (miss_o !== e[2:0]) begin
      n_fail++; $display("FAIL miss_set: got %b expected %b", miss_o, e[2:0]);
    end
    e = sb.pop_front(); n_checks++;
    if (int_cnt_o[2*W +: W] !== e[W-1:0]) begin
      n_fail++; $display("FAIL miss_cnt2: got %0d expected %0d", int_cnt_o[2*W +: W], e[W-1:0]);
    end
    cnt_clr_i = 1'b1;
    src_i = 3'b100;
    sb.push_back(1);
    sb.push_back(0);
    step();
    cnt_clr_i = 1'b0;
    src_i = '0;
    e = sb.pop_front(); n_checks++;
    if (int_cnt_o[2*W +: W] !== e[W-1:0]) begin
      n_fail++; $display("FAIL cntclr_edge_cnt2: got %0d expected %0d", int_cnt_o[2*W +: W], e[W-1:0]);
    end
    e = sb.pop_front(); n_checks++;
    if (miss_o !== e[2:0]) begin
      n_fail++; $display("FAIL cntclr_miss: got %b expected %b", miss_o, e[2:0]);
    end
  endtask

  task automatic test_set_wins();
    apply_reset('0);
    en_i = 3'b010;
    step(2);
    pulse(3'b010);
    src_i = 3'b010;
    clr_i = 3'b010;
    sb.push_back(3'b010);
    sb.push_back(0);
    sb.push_back(1);
    step();
    src_i = '0;
    clr_i = '0;
    e = sb.pop_front(); n_checks++;
    if (pending_o !== e[2:0]) begin
      n_fail++; $display("FAIL setwins_pending: got %b expected %b", pending_o, e[2:0]);
    end
    e = sb.pop_front(); n_checks++;
    if (miss_o !== e[2:0]) begin
      n_fail++; $display("FAIL setwins_no_miss: got %b expected %b", miss_o, e[2:0]);
    end
    e = sb.pop_front(); n_checks++;
    if (irq_o !== e[0]) begin
      n_fail++; $display("FAIL setwins_irq: got %b expected %b", irq_o, e[0]);
    end
    en_i = '0;
    sb.push_back(0);
    sb.push_back(3'b010);
    step();
    e = sb.pop_front(); n_checks++;
    if (irq_o !== e[0]) begin
      n_fail++; $display("FAIL masked_irq: got %b expected %b", irq_o, e[0]);
    end
    e = sb.pop_front(); n_checks++;
    if (pending_o !== e[2:0]) begin
      n_fail++; $display("FAIL masked_pending: got %b expected %b", pending_o, e[2:0]);
    end
  endtask

  task automatic test_saturate();
    apply_reset('0);
    en_i = 3'b001;
    step(2);
    repeat (15) pulse(3'b001);
    sb.push_back(15);
    e = sb.pop_front(); n_checks++;
    if (cnt_s[SW-1:0] !== e[SW-1:0]) begin
      n_fail++; $display("FAIL sat_at_max: got %0d expected %0d", cnt_s[SW-1:0], e[SW-1:0]);
    end
    repeat (2) pulse(3'b001);
    sb.push_back(15);
    sb.push_back(17);
    e = sb.pop_front(); n_checks++;
    if (cnt_s[SW-1:0] !== e[SW-1:0]) begin
      n_fail++; $display("FAIL sat_hold: got %0d expected %0d", cnt_s[SW-1:0], e[SW-1:0]);
    end
    e = sb.pop_front(); n_checks++;
    if (int_cnt_o[W-1:0] !== e[W-1:0]) begin
      n_fail++; $display("FAIL wide_cnt17: got %0d expected %0d", int_cnt_o[W-1:0], e[W-1:0]);
    end
  endtask

`ifdef PL_INT_FIQ_ROUTE_EN
  task automatic test_fiq();
    apply_reset('0);
    en_i = 3'b011;
    fiq_sel_i = 3'b001;
    step(2);
    pulse(3'b001);
    sb.push_back(1);
    sb.push_back(0);
    e = sb.pop_front(); n_checks++;
    if (fiq_o !== e[0]) begin
      n_fail++; $display("FAIL fiq_assert: got %b expected %b", fiq_o, e[0]);
    end
    e = sb.pop_front(); n_checks++;
    if (irq_o !== e[0]) begin
      n_fail++; $display("FAIL fiq_irq_quiet: got %b expected %b", irq_o, e[0]);
    end
    pulse(3'b010);
    sb.push_back(1);
    e = sb.pop_front(); n_checks++;
    if (irq_o !== e[0]) begin
      n_fail++; $display("FAIL fiq_irq_src1: got %b expected %b", irq_o, e[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_pulse();
    test_holdoff();
    test_miss();
    test_set_wins();
    test_saturate();
`ifdef PL_INT_FIQ_ROUTE_EN
    test_fiq();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
